// File: rtl/bcd_counter_ndigit.sv
// Purpose : N-digit BCD up/down counter (0 .. 10^DIGITS-1) with enable, checked parallel load,
//           wrap or saturate at the limits, and one-cycle limit/load-error pulses.
// Latency : all outputs registered; an edge's inputs are visible right after that edge, no comb in->out path.
// Backpr. : none; one count step per enabled edge, priority i_rst > i_load > i_en.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst       synchronous reset, active-high
//   i_en        count enable
//   i_up        direction: 1 = up, 0 = down (sampled with i_en)
//   i_load      parallel load request
//   i_load_val  BCD load value, nibble k = digit k
//   o_digits    registered BCD count, nibble k = digit k
//   o_carry     one-cycle pulse on an up step from max or a down step from 0
//   o_load_err  one-cycle pulse when a load is rejected for a non-BCD nibble
module bcd_counter_ndigit #(
    parameter int DIGITS   = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_up,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_val,
    output logic [4*DIGITS-1:0]   o_digits,
    output logic                  o_carry,
    output logic                  o_load_err
);

    logic [4*DIGITS-1:0] r_digits;
    logic                r_carry;
    logic                r_load_err;

    logic [4*DIGITS-1:0] w_next_up;
    logic [4*DIGITS-1:0] w_next_dn;
    logic                w_at_max;
    logic                w_at_min;
    logic                w_load_ok;

    // Ripple evaluated in one pass: digit k moves only when every lower digit
    // is at its rollover value (9 going up, 0 going down). After the last
    // digit the running flags tell whether the whole counter sits at a limit.
    always_comb begin
        logic       l_run9;
        logic       l_run0;
        logic [3:0] l_d;
        w_next_up = '0;
        w_next_dn = '0;
        w_load_ok = 1'b1;
        l_run9    = 1'b1;
        l_run0    = 1'b1;
        l_d       = '0;
        for (int k = 0; k < DIGITS; k++) begin
            l_d = r_digits[4*k +: 4];
            if (l_run9) begin
                w_next_up[4*k +: 4] = (l_d == 4'd9) ? 4'd0 : l_d + 4'd1;
            end else begin
                w_next_up[4*k +: 4] = l_d;
            end
            if (l_run0) begin
                w_next_dn[4*k +: 4] = (l_d == 4'd0) ? 4'd9 : l_d - 4'd1;
            end else begin
                w_next_dn[4*k +: 4] = l_d;
            end
            l_run9 = l_run9 & (l_d == 4'd9);
            l_run0 = l_run0 & (l_d == 4'd0);
            if (i_load_val[4*k +: 4] > 4'd9) begin
                w_load_ok = 1'b0;
            end
        end
        w_at_max = l_run9;
        w_at_min = l_run0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digits   <= '0;
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
        end else if (i_load) begin
            // A rejected load leaves the count untouched so the BCD invariant holds.
            r_carry    <= 1'b0;
            r_load_err <= ~w_load_ok;
            if (w_load_ok) begin
                r_digits <= i_load_val;
            end
        end else if (i_en) begin
            r_load_err <= 1'b0;
            if (i_up) begin
                r_carry <= w_at_max;
                // In wrap mode the ripple from all-9s already yields all-0s.
                if (!(SATURATE && w_at_max)) begin
                    r_digits <= w_next_up;
                end
            end else begin
                r_carry <= w_at_min;
                // In wrap mode the borrow from all-0s already yields all-9s.
                if (!(SATURATE && w_at_min)) begin
                    r_digits <= w_next_dn;
                end
            end
        end else begin
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    assign o_digits   = r_digits;
    assign o_carry    = r_carry;
    assign o_load_err = r_load_err;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Bench for bcd_counter_ndigit: four instances (1, 3 wrap, 3 saturate, 4 digits)
// share one stimulus stream; each is compared every edge with an integer model.
module tb_bcd_counter_ndigit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic        up   = 1'b0;
    logic        load = 1'b0;
    logic [15:0] lv   = '0;

    logic [3:0]  q1;
    logic [11:0] q3, q3s;
    logic [15:0] q4;
    logic        c1, c3, c3s, c4;
    logic        e1, e3, e3s, e4;

    bcd_counter_ndigit #(.DIGITS(1), .SATURATE(1'b0)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load),
        .i_load_val(lv[3:0]), .o_digits(q1), .o_carry(c1), .o_load_err(e1));
    bcd_counter_ndigit #(.DIGITS(3), .SATURATE(1'b0)) u_d3 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load),
        .i_load_val(lv[11:0]), .o_digits(q3), .o_carry(c3), .o_load_err(e3));
    bcd_counter_ndigit #(.DIGITS(3), .SATURATE(1'b1)) u_d3s (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load),
        .i_load_val(lv[11:0]), .o_digits(q3s), .o_carry(c3s), .o_load_err(e3s));
    bcd_counter_ndigit #(.DIGITS(4), .SATURATE(1'b0)) u_d4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load),
        .i_load_val(lv), .o_digits(q4), .o_carry(c4), .o_load_err(e4));

    int checks = 0;
    int errors = 0;

    // Model state: plain decimal values plus expected flag pulses.
    int m1 = 0, m3 = 0, m3s = 0, m4 = 0;
    bit xc1, xc3, xc3s, xc4, xe1, xe3, xe3s, xe4;

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int ref_next(input int v, input int nd, input bit sat,
                                    input bit r, input bit e, input bit u, input bit l,
                                    input logic [15:0] val, output bit c, output bit err);
        int maxv;
        int lval;
        bit ok;
        maxv = 1;
        for (int k = 0; k < nd; k++) maxv = maxv * 10;
        maxv = maxv - 1;
        c = 1'b0;
        err = 1'b0;
        if (r) return 0;
        if (l) begin
            ok = 1'b1;
            lval = 0;
            for (int k = nd - 1; k >= 0; k--) begin
                if (int'(val[4*k +: 4]) > 9) ok = 1'b0;
                lval = lval * 10 + int'(val[4*k +: 4]);
            end
            if (ok) return lval;
            err = 1'b1;
            return v;
        end
        if (e) begin
            if (u) begin
                if (v == maxv) begin
                    c = 1'b1;
                    return sat ? maxv : 0;
                end
                return v + 1;
            end else begin
                if (v == 0) begin
                    c = 1'b1;
                    return sat ? 0 : maxv;
                end
                return v - 1;
            end
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one edge's inputs, advance the models, and compare every instance.
    task automatic tick(input bit r, input bit e, input bit u, input bit l, input logic [15:0] val);
        rst  = r;
        en   = e;
        up   = u;
        load = l;
        lv   = val;
        m1  = ref_next(m1,  1, 1'b0, r, e, u, l, val, xc1,  xe1);
        m3  = ref_next(m3,  3, 1'b0, r, e, u, l, val, xc3,  xe3);
        m3s = ref_next(m3s, 3, 1'b1, r, e, u, l, val, xc3s, xe3s);
        m4  = ref_next(m4,  4, 1'b0, r, e, u, l, val, xc4,  xe4);
        @(posedge clk);
        #1;
        chk("d1_digits",  {12'h000, q1},  int2bcd(m1));
        chk("d1_carry",   {15'h0, c1},    {15'h0, xc1});
        chk("d1_lderr",   {15'h0, e1},    {15'h0, xe1});
        chk("d3_digits",  {4'h0, q3},     int2bcd(m3));
        chk("d3_carry",   {15'h0, c3},    {15'h0, xc3});
        chk("d3_lderr",   {15'h0, e3},    {15'h0, xe3});
        chk("d3s_digits", {4'h0, q3s},    int2bcd(m3s));
        chk("d3s_carry",  {15'h0, c3s},   {15'h0, xc3s});
        chk("d3s_lderr",  {15'h0, e3s},   {15'h0, xe3s});
        chk("d4_digits",  q4,             int2bcd(m4));
        chk("d4_carry",   {15'h0, c4},    {15'h0, xc4});
        chk("d4_lderr",   {15'h0, e4},    {15'h0, xe4});
    endtask

    initial begin
        int carry_edge;
        int carry_cnt;
        logic [15:0] rv;

        // Reset for two edges, then count up through the full range.
        tick(1, 0, 0, 0, 16'h0);
        tick(1, 0, 0, 0, 16'h0);
        chk("rst_digits", {4'h0, q3}, 16'h000);
        chk("rst_carry",  {15'h0, c3}, 16'h0);
        carry_edge = -1;
        carry_cnt  = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(0, 1, 1, 0, 16'h0);
            if (c3 === 1'b1) begin
                carry_cnt++;
                carry_edge = i;
            end
        end
        chk("t1_wrap_digits", {4'h0, q3}, 16'h000);
        chk("t1_carry_count", 16'(carry_cnt), 16'd1);
        chk("t1_carry_edge",  16'(carry_edge), 16'd999);

        // Ripple borrow across two digits, then wrap below zero.
        tick(0, 0, 0, 1, 16'h0100);
        chk("t2_load", {4'h0, q3}, 16'h100);
        tick(0, 1, 0, 0, 16'h0);
        chk("t2_099", {4'h0, q3}, 16'h099);
        tick(0, 1, 0, 0, 16'h0);
        chk("t2_098", {4'h0, q3}, 16'h098);
        for (int i = 0; i < 98; i++) tick(0, 1, 0, 0, 16'h0);
        chk("t2_000", {4'h0, q3}, 16'h000);
        chk("t2_000_carry", {15'h0, c3}, 16'h0);
        tick(0, 1, 0, 0, 16'h0);
        chk("t2_999", {4'h0, q3}, 16'h999);
        chk("t2_999_carry", {15'h0, c3}, 16'h1);

        // Saturating instance holds at max with Carry on every enabled edge.
        tick(0, 0, 0, 1, 16'h0998);
        tick(0, 1, 1, 0, 16'h0);
        chk("t3_s1", {4'h0, q3s}, 16'h999);
        chk("t3_c1", {15'h0, c3s}, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 1, 0, 16'h0);
            chk("t3_sat_hold", {4'h0, q3s}, 16'h999);
            chk("t3_sat_carry", {15'h0, c3s}, 16'h1);
        end

        // Rejected load keeps the count; a valid load afterwards is taken.
        tick(0, 0, 0, 1, 16'h0042);
        tick(0, 0, 0, 1, 16'h01A5);
        chk("t4_keep", {4'h0, q3}, 16'h042);
        chk("t4_err", {15'h0, e3}, 16'h1);
        tick(0, 0, 0, 0, 16'h0);
        chk("t4_err_clr", {15'h0, e3}, 16'h0);
        tick(0, 0, 0, 1, 16'h0765);
        chk("t4_765", {4'h0, q3}, 16'h765);
        chk("t4_765_err", {15'h0, e3}, 16'h0);

        // Load beats En; reset beats Load.
        tick(0, 0, 0, 1, 16'h0123);
        tick(0, 1, 1, 1, 16'h0500);
        chk("t5_load_pri", {4'h0, q3}, 16'h500);
        tick(1, 0, 0, 1, 16'h0777);
        chk("t5_rst_pri", {4'h0, q3}, 16'h000);

        // Reset mid-count wins over the ripple.
        tick(0, 0, 0, 1, 16'h0598);
        tick(0, 1, 1, 0, 16'h0);
        chk("t6_599", {4'h0, q3}, 16'h599);
        tick(1, 1, 1, 0, 16'h0);
        chk("t6_rst_digits", {4'h0, q3}, 16'h000);
        chk("t6_rst_carry", {15'h0, c3}, 16'h0);

        // Random stimulus against the models on all instances.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                for (int k = 0; k < 4; k++) rv[4*k +: 4] = 4'($urandom_range(9, 0));
            end else begin
                rv = 16'($urandom);
            end
            tick($urandom_range(499, 0) == 0, 1'($urandom), 1'($urandom),
                 $urandom_range(15, 0) == 0, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
